// File: rtl/sprite_fb_writer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fb_writer
// Description : Sweeps WriteX/WriteY over the frame and takes the highest-
//               priority sprite layer that is on. It reads the sprite ROM,
//               resolves transparency and background, and streams palette
//               indices to the frame buffer through a credit-limited FIFO.
//               Optional build macro: SPRITE_FB_STATS_EN (adds
//               sprite_px_count).
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_fb_writer #(
    parameter int NUM_LAYERS  = 4,
    parameter int PIX_W       = 4,
    parameter int ROM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int TRANSP_IDX  = 0,
    parameter int DAY_BG      = 1,
    parameter int NIGHT_BG    = 2
) (
    input  logic                     Clk50,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     isnight,
    output logic [9:0]               WriteX,
    output logic [9:0]               WriteY,
    input  logic [NUM_LAYERS-1:0]    layer_on,
    input  logic [NUM_LAYERS*18-1:0] layer_addr,
    output logic                     rom_rd,
    output logic [17:0]              rom_addr,
    input  logic [PIX_W-1:0]         rom_data,
    output logic                     fb_we,
    output logic [18:0]              fb_addr,
    output logic [PIX_W-1:0]         fb_data,
    input  logic                     fb_ready,
    output logic                     busy,
    output logic                     frame_done
`ifdef SPRITE_FB_STATS_EN
    ,
    output logic [19:0]              sprite_px_count
`endif
);

    localparam logic [1:0]       c_IDLE   = 2'd0;
    localparam logic [1:0]       c_SWEEP  = 2'd1;
    localparam logic [1:0]       c_DRAIN  = 2'd2;
    localparam int               c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int               c_CNT_W  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;
    localparam logic [9:0]       c_X_LAST = 10'(H_RES - 1);
    localparam logic [9:0]       c_Y_LAST = 10'(V_RES - 1);
    localparam logic [18:0]      c_H_RES  = 19'(H_RES);
    localparam logic [PIX_W-1:0] c_TRANSP = PIX_W'(TRANSP_IDX);
    localparam logic [PIX_W-1:0] c_DAY    = PIX_W'(DAY_BG);
    localparam logic [PIX_W-1:0] c_NIGHT  = PIX_W'(NIGHT_BG);

    logic [1:0]             state_q, state_d;
    logic [9:0]             x_q, x_d, y_q, y_d;
    logic [ROM_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_hit_q, pipe_hit_d;
    logic [18:0]            pipe_addr_q [ROM_LATENCY];
    logic [18:0]            pipe_addr_d [ROM_LATENCY];
    logic [PIX_W-1:0]       pipe_bg_q   [ROM_LATENCY];
    logic [PIX_W-1:0]       pipe_bg_d   [ROM_LATENCY];
    logic [c_PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [18:0]            fifo_addr_mem [FIFO_DEPTH];
    logic [PIX_W-1:0]       fifo_data_mem [FIFO_DEPTH];

    logic                   w_hit;
    logic [17:0]            w_sel_addr;
    logic [c_CNT_W-1:0]     w_inflight;
    logic                   w_issue;
    logic                   w_drained;
    logic [18:0]            w_pix_addr;
    logic [PIX_W-1:0]       w_bg;
    logic                   w_push, w_pop, w_push_sprite;
    logic [PIX_W-1:0]       w_push_data;

    // Priority select: iterate high to low so the lowest active layer wins.
    always_comb begin
        w_hit      = 1'b0;
        w_sel_addr = 18'd0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_on[i]) begin
                w_hit      = 1'b1;
                w_sel_addr = layer_addr[18*i +: 18];
            end
        end
    end

    // In-flight count is the number of occupied ROM pipeline stages.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < ROM_LATENCY; k++) begin
            w_inflight = w_inflight + c_CNT_W'(pipe_vld_q[k]);
        end
    end

    // Issue credit: FIFO slots already promised plus stored must leave room.
    assign w_issue    = (state_q == c_SWEEP) &&
                        ((fifo_cnt_q + w_inflight) < c_CNT_W'(FIFO_DEPTH));
    assign w_drained  = (fifo_cnt_q == '0) && (w_inflight == '0);
    assign w_pix_addr = (19'(y_q) * c_H_RES) + 19'(x_q);
    assign w_bg       = isnight ? c_NIGHT : c_DAY;

    assign rom_rd     = w_issue && w_hit;
    assign rom_addr   = rom_rd ? w_sel_addr : 18'd0;

    // Pipeline exit lines up with rom_data for the read issued ROM_LATENCY ago.
    assign w_push        = pipe_vld_q[ROM_LATENCY-1];
    assign w_push_sprite = pipe_hit_q[ROM_LATENCY-1] && (rom_data != c_TRANSP);
    assign w_push_data   = w_push_sprite ? rom_data : pipe_bg_q[ROM_LATENCY-1];

    assign fb_we      = (fifo_cnt_q != '0);
    assign w_pop      = fb_we && fb_ready;
    assign fb_addr    = fb_we ? fifo_addr_mem[rd_ptr_q] : 19'd0;
    assign fb_data    = fb_we ? fifo_data_mem[rd_ptr_q] : '0;

    assign WriteX     = x_q;
    assign WriteY     = y_q;
    assign busy       = (state_q == c_SWEEP) || (state_q == c_DRAIN);
    assign frame_done = (state_q == c_DRAIN) && w_drained;

    // Sweep FSM and raster coordinate advance.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            c_IDLE: begin
                if (frame_start) state_d = c_SWEEP;
            end
            c_SWEEP: begin
                if (w_issue) begin
                    if (x_q == c_X_LAST) begin
                        x_d = 10'd0;
                        if (y_q == c_Y_LAST) begin
                            y_d     = 10'd0;
                            state_d = c_DRAIN;
                        end else begin
                            y_d = y_q + 10'd1;
                        end
                    end else begin
                        x_d = x_q + 10'd1;
                    end
                end
            end
            c_DRAIN: begin
                if (w_drained) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ROM-latency shift pipeline carrying {valid, hit, fb address, background}.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_hit_d     = pipe_hit_q;
        pipe_addr_d    = pipe_addr_q;
        pipe_bg_d      = pipe_bg_q;
        pipe_vld_d[0]  = w_issue;
        pipe_hit_d[0]  = w_issue && w_hit;
        pipe_addr_d[0] = w_pix_addr;
        pipe_bg_d[0]   = w_bg;
        for (int k = 1; k < ROM_LATENCY; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_hit_d[k]  = pipe_hit_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
            pipe_bg_d[k]   = pipe_bg_q[k-1];
        end
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + c_PTR_W'(w_push);
        rd_ptr_d   = rd_ptr_q + c_PTR_W'(w_pop);
        fifo_cnt_d = fifo_cnt_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= c_IDLE;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            pipe_vld_q <= '0;
            pipe_hit_q <= '0;
            for (int k = 0; k < ROM_LATENCY; k++) begin
                pipe_addr_q[k] <= 19'd0;
                pipe_bg_q[k]   <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_hit_q  <= pipe_hit_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_bg_q   <= pipe_bg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents are masked by the occupancy count, so no reset.
    always_ff @(posedge Clk50) begin
        if (w_push) begin
            fifo_addr_mem[wr_ptr_q] <= pipe_addr_q[ROM_LATENCY-1];
            fifo_data_mem[wr_ptr_q] <= w_push_data;
        end
    end

`ifdef SPRITE_FB_STATS_EN
    logic [19:0] stat_cnt_q, stat_cnt_d, stat_out_q, stat_out_d;

    // Count sprite-sourced pixels per frame; publish the total at frame end.
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if ((state_q == c_IDLE) && frame_start) begin
            stat_cnt_d = 20'd0;
        end else if (w_push && w_push_sprite) begin
            stat_cnt_d = stat_cnt_q + 20'd1;
        end
        stat_out_d = frame_done ? stat_cnt_q : stat_out_q;
    end

    // Statistics registers.
    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_cnt_q <= 20'd0;
            stat_out_q <= 20'd0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
            stat_out_q <= stat_out_d;
        end
    end

    assign sprite_px_count = stat_out_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_fb_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sprite_fb_writer
// Description : Self-checking bench for sprite_fb_writer. The frame height is
//               reduced to keep the run short; the line width is the real
//               640 pixels, so raster addresses match the full-size frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_fb_writer;

    localparam int NL     = 4;
    localparam int PW     = 4;
    localparam int RL     = 2;
    localparam int FD     = 4;
    localparam int HR     = 640;
    localparam int VR     = 8;
    localparam int NPIX   = HR * VR;
    localparam int BUDGET = 30000;

    logic            Clk50 = 1'b0;
    logic            Reset_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            isnight;
    logic [9:0]      WriteX, WriteY;
    logic [NL-1:0]   layer_on;
    logic [NL*18-1:0] layer_addr;
    logic            rom_rd;
    logic [17:0]     rom_addr;
    logic [PW-1:0]   rom_data;
    logic            fb_we;
    logic [18:0]     fb_addr;
    logic [PW-1:0]   fb_data;
    logic            fb_ready = 1'b0;
    logic            busy, frame_done;
`ifdef SPRITE_FB_STATS_EN
    logic [19:0]     sprite_px_count;
`endif

    sprite_fb_writer #(.V_RES(VR)) dut (
        .Clk50(Clk50), .Reset_n(Reset_n), .frame_start(frame_start),
        .isnight(isnight), .WriteX(WriteX), .WriteY(WriteY),
        .layer_on(layer_on), .layer_addr(layer_addr),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .busy(busy), .frame_done(frame_done)
`ifdef SPRITE_FB_STATS_EN
        , .sprite_px_count(sprite_px_count)
`endif
    );

    always #5 Clk50 = ~Clk50;

    int          checks = 0;
    int          errors = 0;
    int          mode = 0;
    logic [31:0] seed = 32'd0;
    int          cyc = 0;
    int          issued = 0, written = 0, exp_idx = 0, done_cnt = 0;
    int          last_issue_cyc = -1, done_cyc = -1, issue_1005_cyc = -100;
    logic [9:0]  prev_x = 10'd0, prev_y = 10'd0;
    bit          stall_active = 1'b0;

    // ---------------- scene (draw blocks) and reference model ----------------
    function automatic logic [31:0] hash(input logic [31:0] a);
        logic [31:0] v;
        v = a ^ (a >> 16);
        v = v * 32'h7feb352d;
        v = v ^ (v >> 15);
        v = v * 32'h846ca68b;
        v = v ^ (v >> 16);
        return v;
    endfunction

    function automatic logic [NL-1:0] on_fn(input int x, input int y, input int m, input logic [31:0] s);
        logic [31:0] h;
        logic [NL-1:0] r;
        h = hash(s ^ 32'(x * 1024 + y));
        case (m)
            0:       r = '0;
            2:       r = (x == 10 && y == 5) ? 4'b0110 : ((x == 0 && y == 0) ? 4'b0001 : 4'b0000);
            default: r = h[NL-1:0];
        endcase
        return r;
    endfunction

    function automatic logic [17:0] addr_fn(input int x, input int y, input int i, input int m, input logic [31:0] s);
        logic [31:0] h;
        logic [17:0] r;
        h = hash(s ^ 32'h9e3779b9 ^ 32'(x * 4096 + y * 4 + i));
        if (m == 2) begin
            if (x == 10 && y == 5 && i == 1)     r = 18'd142615;
            else if (x == 0 && y == 0 && i == 0) r = 18'd16;
            else                                 r = 18'(1000 + i);
        end else begin
            r = h[17:0];
        end
        return r;
    endfunction

    function automatic logic night_fn(input int x, input int y, input int m, input logic [31:0] s);
        logic [31:0] h;
        h = hash(s ^ 32'h01234567 ^ 32'(x * 1024 + y));
        if (m == 0) return 1'b1;
        if (m == 2) return 1'b0;
        return h[9];
    endfunction

    function automatic logic [NL*18-1:0] addr_vec(input int x, input int y, input int m, input logic [31:0] s);
        logic [NL*18-1:0] v;
        v = '0;
        for (int i = 0; i < NL; i++) v[18*i +: 18] = addr_fn(x, y, i, m, s);
        return v;
    endfunction

    // Sprite ROM contents: the palette index is the low nibble of the address.
    function automatic logic [PW-1:0] rom_fn(input logic [17:0] a);
        return a[PW-1:0];
    endfunction

    // Expected palette index for raster position idx.
    function automatic logic [PW-1:0] exp_pix(input int idx, input int m, input logic [31:0] s);
        int x, y;
        logic [NL-1:0] on;
        logic [PW-1:0] bg, d;
        x  = idx % HR;
        y  = idx / HR;
        bg = night_fn(x, y, m, s) ? 4'd2 : 4'd1;
        on = on_fn(x, y, m, s);
        for (int i = 0; i < NL; i++) begin
            if (on[i]) begin
                d = rom_fn(addr_fn(x, y, i, m, s));
                return (d == 4'd0) ? bg : d;
            end
        end
        return bg;
    endfunction

    always_comb begin
        layer_on   = on_fn(int'(WriteX), int'(WriteY), mode, seed);
        layer_addr = addr_vec(int'(WriteX), int'(WriteY), mode, seed);
        isnight    = night_fn(int'(WriteX), int'(WriteY), mode, seed);
    end

    // Sprite ROM with fixed two-cycle read latency.
    logic [17:0] rq1 = 18'h3FFFF, rq2 = 18'h3FFFF;
    always @(posedge Clk50) begin
        rq1 <= rom_rd ? rom_addr : 18'h3FFFF;
        rq2 <= rq1;
    end
    assign rom_data = rom_fn(rq2);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive fb_ready, and check any write that completes.
    task automatic step(input bit rnd);
        @(posedge Clk50);
        #1;
        cyc++;
        if (WriteX !== prev_x || WriteY !== prev_y) begin
            issued++;
            if (prev_x == 10'(HR - 1) && prev_y == 10'(VR - 1)) last_issue_cyc = cyc - 1;
        end
        prev_x = WriteX;
        prev_y = WriteY;
        fb_ready = stall_active ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        #1;
        chk("outstanding_le_depth", 32'(issued - written <= FD), 32'd1);
        if (mode == 2 && busy && WriteX == 10'd10 && WriteY == 10'd5) begin
            chk("rom_rd_10_5", 32'(rom_rd), 32'd1);
            chk("rom_addr_10_5", 32'(rom_addr), 32'd142615);
            issue_1005_cyc = cyc;
        end
        if (mode == 2 && busy && issued == 0 && written == 0) begin
            chk("rom_rd_0_0", 32'(rom_rd), 32'd1);
            chk("rom_addr_0_0", 32'(rom_addr), 32'd16);
        end
        if (fb_we && fb_ready) begin
            chk("fb_addr", 32'(fb_addr), 32'(exp_idx));
            chk("fb_data", 32'(fb_data), 32'(exp_pix(exp_idx, mode, seed)));
            if (mode == 2 && fb_addr == 19'd3210) chk("latency_3210", 32'(cyc - issue_1005_cyc), 32'd3);
            exp_idx++;
            written++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic start_frame(input int m, input bit rnd);
        mode           = m;
        seed           = $urandom;
        exp_idx        = 0;
        issued         = 0;
        written        = 0;
        done_cnt       = 0;
        issue_1005_cyc = -100;
        last_issue_cyc = -1;
        done_cyc       = -1;
        frame_start    = 1'b1;
        step(rnd);
        frame_start    = 1'b0;
    endtask

    task automatic run_frame(input int m, input bit rnd, input bit do_stall, input bit poke);
        int n;
        bit poked;
        logic [9:0] sx, sy;
        n     = 0;
        poked = 1'b0;
        start_frame(m, rnd);
        chk("busy_after_start", 32'(busy), 32'd1);
        while (done_cnt == 0 && n < BUDGET) begin
            if (do_stall && n == 1000) begin
                stall_active = 1'b1;
                repeat (10) step(rnd);
                sx = WriteX;
                sy = WriteY;
                repeat (10) step(rnd);
                chk("stall_hold_x", 32'(WriteX), 32'(sx));
                chk("stall_hold_y", 32'(WriteY), 32'(sy));
                chk("stall_outstanding", 32'(issued - written), 32'(FD));
                stall_active = 1'b0;
                n += 20;
            end
            if (poke && !poked && last_issue_cyc >= 0 && done_cnt == 0) begin
                frame_start = 1'b1;
                poked = 1'b1;
            end
            step(rnd);
            frame_start = 1'b0;
            n++;
        end
        chk("frame_done_seen", 32'(done_cnt), 32'd1);
        if (!rnd) chk("done_latency_ok", 32'(done_cyc - last_issue_cyc <= FD + RL + 1), 32'd1);
        repeat (12) step(rnd);
        chk("frame_done_once", 32'(done_cnt), 32'd1);
        chk("write_count", 32'(written), 32'(NPIX));
        chk("busy_low_after", 32'(busy), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_WriteX"}, 32'(WriteX), 32'd0);
        chk({tag, "_WriteY"}, 32'(WriteY), 32'd0);
        chk({tag, "_rom_rd"}, 32'(rom_rd), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        chk({tag, "_fb_data"}, 32'(fb_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int we_cnt;

        // Power-on reset.
        repeat (3) @(posedge Clk50);
        #1;
        chk_outputs_zero("reset");
        Reset_n = 1'b1;

        // Reset asserted in the middle of a sweep.
        start_frame(1, 1'b1);
        n = 0;
        while (!(WriteX == 10'd100 && WriteY == 10'd3) && n < BUDGET) begin
            step(1'b1);
            n++;
        end
        chk("reached_100_3", 32'(WriteX == 10'd100 && WriteY == 10'd3), 32'd1);
        Reset_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(posedge Clk50);
        #1;
        Reset_n = 1'b1;
        prev_x = 10'd0;
        prev_y = 10'd0;
        we_cnt = 0;
        repeat (30) begin
            @(posedge Clk50);
            #1;
            fb_ready = 1'b1;
            #1;
            if (fb_we) we_cnt++;
        end
        chk("no_we_after_reset", 32'(we_cnt), 32'd0);
        chk("idle_after_reset", 32'(busy), 32'd0);

        // All-miss night frame: every pixel is NIGHT_BG.
        run_frame(0, 1'b0, 1'b0, 1'b0);
        // Directed hits, day background, frame_start poked during drain.
        run_frame(2, 1'b0, 1'b0, 1'b1);
        // Random scene with random backpressure and a 20-cycle stall.
        run_frame(1, 1'b1, 1'b1, 1'b1);
        // Random scene at full throughput.
        run_frame(1, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
